ex_mem_skid_buffer: RTL and testbench

- EX-to-MEM stage register with a 2-entry skid buffer, sitting directly downstream of the ALU.
- Captures each ALU result together with store data, destination register and MEM/WB control bits.
- Presents them to the MEM stage (L1 data cache) under a valid/ready handshake.
- Decouples the cache's combinational stall path from EX: backpressure reaches EX only through a registered ready.

---
 rtl/ex_mem_skid_buffer.sv | 146 ++++++++++++++
 tb/tb_ex_mem_skid_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_buffer.sv
// rtl/ex_mem_skid_buffer.sv - EX/MEM stage register with 2-entry skid buffer and stall counter
module ex_mem_skid_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] WriteData_i,
    input  logic [REG_W-1:0]  RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic [REG_W-1:0]  RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              load_head_in, load_head_skid, load_skid;
    logic              accept, drain;

    logic [DATA_W-1:0] head_alu_q, head_wd_q, skid_alu_q, skid_wd_q;
    logic [REG_W-1:0]  head_rd_q, skid_rd_q;
    logic [3:0]        head_ctl_q, skid_ctl_q;
    logic [CNT_W-1:0]  stall_q;

    // ready_o depends only on registered state, never on ready_i.
    assign ready_o = (state_q != FULL) && !rst_i;
    assign valid_o = (state_q != EMPTY);
    assign accept  = valid_i && ready_o;
    assign drain   = valid_o && ready_i;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_alu_q <= '0;
            head_wd_q  <= '0;
            head_rd_q  <= '0;
            head_ctl_q <= '0;
        end else if (load_head_in) begin
            head_alu_q <= ALUResult_i;
            head_wd_q  <= WriteData_i;
            head_rd_q  <= RDaddr_i;
            head_ctl_q <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
        end else if (load_head_skid) begin
            head_alu_q <= skid_alu_q;
            head_wd_q  <= skid_wd_q;
            head_rd_q  <= skid_rd_q;
            head_ctl_q <= skid_ctl_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_alu_q <= '0;
            skid_wd_q  <= '0;
            skid_rd_q  <= '0;
            skid_ctl_q <= '0;
        end else if (load_skid) begin
            skid_alu_q <= ALUResult_i;
            skid_wd_q  <= WriteData_i;
            skid_rd_q  <= RDaddr_i;
            skid_ctl_q <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
        end
    end

    // Saturating count of cycles the cache held off a valid beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (valid_o && !ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ALUResult_o = head_alu_q;
    assign WriteData_o = head_wd_q;
    assign RDaddr_o    = head_rd_q;
    assign RegWrite_o  = head_ctl_q[3] && valid_o;
    assign MemtoReg_o  = head_ctl_q[2] && valid_o;
    assign MemRead_o   = head_ctl_q[1] && valid_o;
    assign MemWrite_o  = head_ctl_q[0] && valid_o;
    assign occupancy_o = 2'(state_q);
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// tb/tb_ex_mem_skid_buffer.sv - randomized queue-model bench for ex_mem_skid_buffer
module tb_ex_mem_skid_buffer;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int BW     = 2 * DATA_W + REG_W + 4;
    localparam int OW     = 1 + 1 + 2 + CNT_W + BW;

    typedef logic [BW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_i = 1'b0;
    logic              ready_i = 1'b0;
    beat_t             in_beat = '0;
    logic              ready_o, valid_o;
    logic [DATA_W-1:0] alu_o, wd_o;
    logic [REG_W-1:0]  rd_o;
    logic              rw_o, mtr_o, mr_o, mw_o;
    logic [1:0]        occ_o;
    logic [CNT_W-1:0]  stall_o;
    logic [OW-1:0]     obs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain FIFO of beats plus the last beat seen at the head.
    beat_t            q[$];
    beat_t            last_head;
    logic [CNT_W-1:0] m_stall;

    always #5 clk = ~clk;

    ex_mem_skid_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .ALUResult_i(in_beat[BW-1 -: DATA_W]),
        .WriteData_i(in_beat[BW-1-DATA_W -: DATA_W]),
        .RDaddr_i(in_beat[REG_W+3:4]),
        .RegWrite_i(in_beat[3]), .MemtoReg_i(in_beat[2]),
        .MemRead_i(in_beat[1]), .MemWrite_i(in_beat[0]),
        .valid_o(valid_o), .ready_i(ready_i),
        .ALUResult_o(alu_o), .WriteData_o(wd_o), .RDaddr_o(rd_o),
        .RegWrite_o(rw_o), .MemtoReg_o(mtr_o), .MemRead_o(mr_o), .MemWrite_o(mw_o),
        .occupancy_o(occ_o), .stall_cnt_o(stall_o)
    );

    assign obs = {valid_o, ready_o, occ_o, stall_o, alu_o, wd_o, rd_o, rw_o, mtr_o, mr_o, mw_o};

    function automatic logic [OW-1:0] expv();
        beat_t h;
        logic  v;
        v = (q.size() > 0);
        h = v ? q[0] : last_head;
        if (!v) h[3:0] = 4'b0;
        return {v, (!rst && q.size() < 2), 2'(q.size()), m_stall, h};
    endfunction

    function automatic beat_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [3:0] ctl);
        return {alu, wd, rd, ctl};
    endfunction

    task automatic model_reset();
        q.delete();
        last_head = '0;
        m_stall   = '0;
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge.
    task automatic cycle(input logic v, input beat_t b, input logic r);
        logic acc, drn, stl;
        valid_i = v;
        in_beat = b;
        ready_i = r;
        acc = v && (q.size() < 2) && !rst;
        drn = (q.size() > 0) && r;
        stl = (q.size() > 0) && !r;
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(b);
        if (stl && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
        if (q.size() > 0) last_head = q[0];
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        model_reset();
        n_vec++;
        if (obs !== expv()) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", obs, expv());
        end
        n_vec++;
        if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got=%b exp=0", ready_o);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready got=%b exp=1", ready_o);
        end
        cycle(1'b1, mk(32'h55, 32'h0, 5'd1, 4'b1000), 1'b1);
        n_vec++;
        if (valid_o !== 1'b1 || alu_o !== 32'h55) begin
            n_err++;
            $display("FAIL first_accept got v=%b alu=%h exp v=1 alu=00000055", valid_o, alu_o);
        end
    endtask

    task automatic test_stream();
        beat_t b[3];
        do_reset();
        b[0] = mk(32'h10, 32'h0, 5'd3, 4'b1000);
        b[1] = mk(32'h20, 32'h0, 5'd4, 4'b1000);
        b[2] = mk(32'h30, 32'h0, 5'd5, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, b[i], 1'b1);
            n_vec++;
            if (alu_o !== 32'h10 * (i + 1) || occ_o !== 2'd1 || ready_o !== 1'b1 || obs !== expv()) begin
                n_err++;
                $display("FAIL stream_%0d got alu=%h occ=%0d rdy=%b exp alu=%h occ=1 rdy=1",
                         i, alu_o, occ_o, ready_o, 32'h10 * (i + 1));
            end
        end
        cycle(1'b0, '0, 1'b1);
        n_vec++;
        if (valid_o !== 1'b0 || rw_o !== 1'b0 || alu_o !== 32'h30) begin
            n_err++;
            $display("FAIL stream_empty got v=%b rw=%b alu=%h exp v=0 rw=0 alu=00000030", valid_o, rw_o, alu_o);
        end
    endtask

    task automatic test_backpressure();
        beat_t a, b, c;
        do_reset();
        a = mk(32'h100, 32'hDEADBEEF, 5'd0, 4'b0001);
        b = mk(32'h200, 32'h12345678, 5'd7, 4'b1010);
        c = mk(32'h300, 32'h0, 5'd9, 4'b1000);
        cycle(1'b1, a, 1'b0);
        cycle(1'b1, b, 1'b0);
        n_vec++;
        if (occ_o !== 2'd2 || ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occ_o, ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, c, 1'b0);
            n_vec++;
            if (alu_o !== 32'h100 || wd_o !== 32'hDEADBEEF || mw_o !== 1'b1 || obs !== expv()) begin
                n_err++;
                $display("FAIL bp_hold_%0d got alu=%h wd=%h mw=%b exp alu=00000100 wd=deadbeef mw=1",
                         i, alu_o, wd_o, mw_o);
            end
        end
        cycle(1'b1, c, 1'b1);
        n_vec++;
        if (alu_o !== 32'h200 || rd_o !== 5'd7 || occ_o !== 2'd1) begin
            n_err++;
            $display("FAIL bp_drain_b got alu=%h rd=%0d occ=%0d exp alu=00000200 rd=7 occ=1", alu_o, rd_o, occ_o);
        end
        cycle(1'b1, c, 1'b1);
        n_vec++;
        if (alu_o !== 32'h300 || occ_o !== 2'd1) begin
            n_err++;
            $display("FAIL bp_drain_c got alu=%h occ=%0d exp alu=00000300 occ=1", alu_o, occ_o);
        end
        cycle(1'b0, '0, 1'b1);
        n_vec++;
        if (valid_o !== 1'b0 || stall_o !== 4'd4 || obs !== expv()) begin
            n_err++;
            $display("FAIL bp_end got v=%b stall=%0d exp v=0 stall=4", valid_o, stall_o);
        end
    endtask

    task automatic test_accept_drain();
        do_reset();
        cycle(1'b1, mk(32'hAAAA0001, 32'h1, 5'd10, 4'b1100), 1'b1);
        cycle(1'b1, mk(32'hBBBB0002, 32'h2, 5'd11, 4'b0010), 1'b1);
        n_vec++;
        if (occ_o !== 2'd1 || alu_o !== 32'hBBBB0002 || mr_o !== 1'b1 || rw_o !== 1'b0) begin
            n_err++;
            $display("FAIL accept_drain got occ=%0d alu=%h mr=%b rw=%b exp occ=1 alu=bbbb0002 mr=1 rw=0",
                     occ_o, alu_o, mr_o, rw_o);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        cycle(1'b1, mk(32'h400, 32'hCAFE, 5'd2, 4'b0001), 1'b0);
        cycle(1'b1, mk(32'h500, 32'hF00D, 5'd3, 4'b0001), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (valid_o !== 1'b0 || occ_o !== 2'd0 || mw_o !== 1'b0 || obs !== expv()) begin
            n_err++;
            $display("FAIL async_reset got v=%b occ=%0d mw=%b exp v=0 occ=0 mw=0", valid_o, occ_o, mw_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1);
            n_vec++;
            if (valid_o !== 1'b0 || occ_o !== 2'd0) begin
                n_err++;
                $display("FAIL reset_no_ghost_%0d got v=%b occ=%0d exp v=0 occ=0", i, valid_o, occ_o);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cycle(1'b1, mk(32'h600, 32'h0, 5'd1, 4'b1000), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0);
        n_vec++;
        if (stall_o !== 4'd15 || obs !== expv()) begin
            n_err++;
            $display("FAIL stall_saturate got=%0d exp=15", stall_o);
        end
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
        n_vec++;
        if (stall_o !== 4'd0) begin
            n_err++;
            $display("FAIL stall_empty got=%0d exp=0", stall_o);
        end
    endtask

    task automatic test_random();
        beat_t b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            b = {$urandom, $urandom, 5'($urandom), 4'($urandom)};
            cycle(($urandom % 4) != 0, b, ($urandom % 3) != 0);
            n_vec++;
            if (obs !== expv()) begin
                n_err++;
                $display("FAIL random_%0d got=%h exp=%h", i, obs, expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_accept_drain();
        test_reset_full();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
